clk_div_prog: RTL and testbench

- Runtime-programmable clock-enable divider. Generates a divided square wave with programmable period and high time, plus a one-cycle wrap tick.
- Drives decimation and level strobes in the wavelet datapath. All logic runs on the system clock, so no derived clocks are produced.
- Successor to the fixed divide-by-N counter: adds run-time ratio and duty, a config handshake with boundary-aligned update, and phase resync.

---
 rtl/clk_div_prog_if.sv | 24 ++
 rtl/clk_div_prog.sv | 130 +++++++++++++
 tb/tb_clk_div_prog.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Configuration handshake bundle for the programmable clock-enable divider.
// The source offers a new ratio and duty; the divider accepts it into its shadow slot.
interface clk_div_prog_if #(
    parameter int W = 8
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_high;

    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_high,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock-enable divider: square wave, wrap tick, shadowed config.
// Optional single-period mode enabled by defining CLK_DIV_ONESHOT_EN.
module clk_div_prog #(
    parameter int W        = 8,
    parameter int DEF_DIV  = 1,
    parameter int DEF_HIGH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sync,
    clk_div_prog_if.slave       cfg,
`ifdef CLK_DIV_ONESHOT_EN
    input  logic                oneshot,
`endif
    output logic                out,
    output logic                tick,
    output logic [W-1:0]        active_div
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] high_q, high_d;
    logic [W-1:0] sh_div_q, sh_div_d;
    logic [W-1:0] sh_high_q, sh_high_d;
    logic         pend_q, pend_d;
    logic         ready_q, ready_d;
    logic         out_q, out_d;

    logic at_end;
    logic hold;
    logic stop;
    logic wrap;
    logic apply;
    logic capture;

`ifdef CLK_DIV_ONESHOT_EN
    logic done_q, done_d;

    // After the single period completes the counter parks at div_act.
    assign hold = done_q & oneshot;
    assign stop = oneshot;

    always_comb begin
        done_d = done_q;
        if (sync || !oneshot) begin
            done_d = 1'b0;
        end else if (wrap) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end
`else
    assign hold = 1'b0;
    assign stop = 1'b0;
`endif

    assign at_end  = (cnt_q == div_q);
    assign wrap    = en & at_end & ~sync & ~hold;
    assign apply   = pend_q & (sync | wrap);
    assign capture = cfg.cfg_valid & ready_q;

    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        high_d    = high_q;
        sh_div_d  = sh_div_q;
        sh_high_d = sh_high_q;
        pend_d    = pend_q;

        if (apply) begin
            div_d  = sh_div_q;
            high_d = sh_high_q;
            pend_d = 1'b0;
        end

        // ready implies no pending entry, so capture never races apply
        if (capture) begin
            sh_div_d  = cfg.cfg_div;
            sh_high_d = cfg.cfg_high;
            pend_d    = 1'b1;
        end

        if (sync) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = stop ? div_d : '0;
        end else if (en && !hold) begin
            cnt_d = cnt_q + W'(1);
        end

        ready_d = ~pend_d;
        out_d   = (cnt_d < high_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= W'(DEF_DIV);
            high_q    <= W'(DEF_HIGH);
            sh_div_q  <= W'(DEF_DIV);
            sh_high_q <= W'(DEF_HIGH);
            pend_q    <= 1'b0;
            ready_q   <= 1'b1;
            out_q     <= (DEF_HIGH != 0);
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            high_q    <= high_d;
            sh_div_q  <= sh_div_d;
            sh_high_q <= sh_high_d;
            pend_q    <= pend_d;
            ready_q   <= ready_d;
            out_q     <= out_d;
        end
    end

    assign tick          = wrap & ~rst;
    assign out           = out_q;
    assign active_div    = div_q;
    assign cfg.cfg_ready = ready_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: directed steps push expected outputs,
// a negedge monitor pops and compares them.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sync;
    logic       out;
    logic       tick;
    logic [7:0] active_div;
`ifdef CLK_DIV_ONESHOT_EN
    logic       oneshot = 1'b0;
`endif

    clk_div_prog_if #(.W(8)) cif ();

    clk_div_prog #(.W(8), .DEF_DIV(1), .DEF_HIGH(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync       (sync),
        .cfg        (cif),
`ifdef CLK_DIV_ONESHOT_EN
        .oneshot    (oneshot),
`endif
        .out        (out),
        .tick       (tick),
        .active_div (active_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       out;
        logic       tick;
        logic       rdy;
        logic [7:0] adiv;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic cmp(input int idx, input string nm,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL step%0d %s: got %0h expected %0h", idx, nm, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            cmp(e.idx, "out",        {7'd0, out},          {7'd0, e.out});
            cmp(e.idx, "tick",       {7'd0, tick},         {7'd0, e.tick});
            cmp(e.idx, "cfg_ready",  {7'd0, cif.cfg_ready}, {7'd0, e.rdy});
            cmp(e.idx, "active_div", active_div,           e.adiv);
        end
    end

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic s(input logic r, input logic e, input logic sy,
                     input logic cv, input logic [7:0] cd, input logic [7:0] ch,
                     input logic eo, input logic et, input logic er,
                     input logic [7:0] ea);
        exp_t x;
        rst           = r;
        en            = e;
        sync          = sy;
        cif.cfg_valid = cv;
        cif.cfg_div   = cd;
        cif.cfg_high  = ch;
        x.idx  = step_no;
        x.out  = eo;
        x.tick = et;
        x.rdy  = er;
        x.adiv = ea;
        sbq.push_back(x);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        sync          = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_div   = 8'd0;
        cif.cfg_high  = 8'd0;
        @(posedge clk);
        #1;

        // reset state held
        s(1, 1, 0, 0, 0, 0,  1, 0, 1, 8'd1);

        // default divide by 2
        for (int i = 0; i < 8; i++)
            s(0, 1, 0, 0, 0, 0,  (i % 2 == 0), (i % 2 == 1), 1, 8'd1);

        // offer div=4 high=2 at cnt=0, applied at the wrap
        s(0, 1, 0, 1, 8'd4, 8'd2,  1, 0, 1, 8'd1);
        s(0, 1, 0, 0, 8'd0, 8'd0,  0, 1, 0, 8'd1);
        for (int i = 0; i < 10; i++)
            s(0, 1, 0, 0, 0, 0,  ((i % 5) < 2), ((i % 5) == 4), 1, 8'd4);

        // high=0 -> constant low
        s(0, 1, 0, 1, 8'd4, 8'd0,  1, 0, 1, 8'd4);
        for (int i = 1; i < 5; i++)
            s(0, 1, 0, 0, 0, 0,  (i < 2), (i == 4), 0, 8'd4);
        for (int i = 0; i < 5; i++)
            s(0, 1, 0, 0, 0, 0,  0, (i == 4), 1, 8'd4);

        // high=7 > div -> constant high
        s(0, 1, 0, 1, 8'd4, 8'd7,  0, 0, 1, 8'd4);
        for (int i = 1; i < 5; i++)
            s(0, 1, 0, 0, 0, 0,  0, (i == 4), 0, 8'd4);
        for (int i = 0; i < 5; i++)
            s(0, 1, 0, 0, 0, 0,  1, (i == 4), 1, 8'd4);

        // sync at cnt=3 applies pending div=2 high=1
        s(0, 1, 0, 1, 8'd2, 8'd1,  1, 0, 1, 8'd4);
        s(0, 1, 0, 0, 0, 0,  1, 0, 0, 8'd4);
        s(0, 1, 0, 0, 0, 0,  1, 0, 0, 8'd4);
        s(0, 1, 1, 0, 0, 0,  1, 0, 0, 8'd4);
        for (int i = 0; i < 6; i++)
            s(0, 1, 0, 0, 0, 0,  ((i % 3) == 0), ((i % 3) == 2), 1, 8'd2);

        // sync at cnt==div suppresses the tick
        s(0, 1, 0, 0, 0, 0,  1, 0, 1, 8'd2);
        s(0, 1, 0, 0, 0, 0,  0, 0, 1, 8'd2);
        s(0, 1, 1, 0, 0, 0,  0, 0, 1, 8'd2);

        // en pause at cnt==div, second offer held until the wrap
        s(0, 1, 0, 1, 8'd3, 8'd3,  1, 0, 1, 8'd2);
        s(0, 1, 0, 1, 8'd5, 8'd5,  0, 0, 0, 8'd2);
        s(0, 0, 0, 1, 8'd5, 8'd5,  0, 0, 0, 8'd2);
        s(0, 0, 0, 1, 8'd5, 8'd5,  0, 0, 0, 8'd2);
        s(0, 1, 0, 1, 8'd5, 8'd5,  0, 1, 0, 8'd2);
        s(0, 1, 0, 1, 8'd5, 8'd5,  1, 0, 1, 8'd3);
        s(0, 1, 0, 0, 0, 0,  1, 0, 0, 8'd3);
        s(0, 1, 0, 0, 0, 0,  1, 0, 0, 8'd3);
        s(0, 1, 0, 0, 0, 0,  0, 1, 0, 8'd3);
        for (int i = 0; i < 6; i++)
            s(0, 1, 0, 0, 0, 0,  (i < 5), (i == 5), 1, 8'd5);

        // en pause mid-period delays the tick by two cycles
        s(0, 1, 0, 0, 0, 0,  1, 0, 1, 8'd5);
        s(0, 0, 0, 0, 0, 0,  1, 0, 1, 8'd5);
        s(0, 0, 0, 0, 0, 0,  1, 0, 1, 8'd5);
        for (int i = 1; i < 6; i++)
            s(0, 1, 0, 0, 0, 0,  (i < 5), (i == 5), 1, 8'd5);

        // reset mid-period drops pending config
        s(0, 1, 0, 1, 8'd6, 8'd2,  1, 0, 1, 8'd5);
        s(0, 1, 0, 0, 0, 0,  1, 0, 0, 8'd5);
        s(1, 1, 0, 0, 0, 0,  1, 0, 0, 8'd5);
        for (int i = 0; i < 4; i++)
            s(0, 1, 0, 0, 0, 0,  (i % 2 == 0), (i % 2 == 1), 1, 8'd1);

        en = 1'b0;
        for (int i = 0; i < 4 && sbq.size() != 0; i++)
            @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
